pending_encoder: RTL and testbench
==================================

PENDING_ENCODER -- requirements
Module: pending_encoder

Interface
REQ-001 Parameter WIDTH, default 8: number of request lines; legal range 2..256.
REQ-002 Parameter ROUND_ROBIN, default 0: 0 selects fixed priority, 1 selects round-robin.
REQ-003 Derived constant IDXW = $clog2(WIDTH): index width; not overridable.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 in  input  WIDTH: request lines, sampled every cycle; any number of bits may be set.
REQ-007 clear  input  1: synchronous flush of all stored requests and the output stage.
REQ-008 out_idx  output  IDXW: encoded index of the granted request.
REQ-009 out_valid  output  1: out_idx holds a granted request.
REQ-010 out_ready  input  1: consumer accepts out_idx when out_valid && out_ready.
REQ-011 pending  output  WIDTH: registered set of requests waiting, excluding the one in the output stage.
REQ-012 overflow  output  1: one-cycle pulse; a request arrived on a bit already pending.

Function
REQ-013 The pending update on each edge, with clear low, SHALL be: pending <= (pending & ~load_mask) | in.
- load_mask is the one-hot bit moved into the output stage that cycle; zero if nothing is moved.
REQ-014 The output stage SHALL load when (!out_valid || out_ready) && pending != 0.
- The load sets out_valid=1 and out_idx=selected index, and clears that bit from pending via load_mask.
REQ-015 When (!out_valid || out_ready) && pending == 0, the output stage SHALL set out_valid=0 on that edge.
REQ-016 While out_valid && !out_ready, out_idx and out_valid SHALL hold stable, and pending SHALL only accumulate.
REQ-017 Fixed priority (ROUND_ROBIN=0): the lowest set index of pending SHALL be selected.
REQ-018 Round-robin (ROUND_ROBIN=1): selection SHALL search from (last_idx+1) mod WIDTH upward with wrap.
- last_idx is the most recently loaded index; its reset value is WIDTH-1, so index 0 is searched first.
REQ-019 Latency SHALL be 2 cycles: in[i] high before edge k gives pending[i]=1 after edge k and out_valid=1 with out_idx=i after edge k+1, provided the stage is free.
REQ-020 Sustained throughput SHALL be one grant per cycle while out_ready=1 and pending != 0.
REQ-021 overflow SHALL be registered, asserting for the cycle after an edge on which (in & pending & ~load_mask) != 0.
REQ-022 A request on the bit currently held in the output stage SHALL be stored in pending as a new request and SHALL NOT raise overflow.
REQ-023 A request on a bit loaded on the same edge SHALL re-set that pending bit, per REQ-013.
REQ-024 When clear is high on an edge, it SHALL take priority over in and the handshake:
- pending <= 0, out_valid <= 0, overflow <= 0; last_idx is unchanged.
- Requests presented that cycle are dropped.
REQ-025 out_idx SHALL be driven from a register, never combinationally from in.

Reset
REQ-026 Asserting rst SHALL immediately force pending=0, out_valid=0, out_idx=0, overflow=0 and last_idx=WIDTH-1, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard the held grant and all pending requests; nothing is replayed after release.
REQ-028 The first edge after rst deasserts SHALL behave as a normal cycle: in is sampled.

Structure
REQ-029 A shared package SHALL hold the mode constants PRIO_FIXED=0 and PRIO_RR=1, plus a clog2-safe index-width function.
REQ-030 Index selection SHALL be one combinational sub-module, prio_pick (WIDTH request vector and start index in; one-hot mask, index and found out).
- Fixed mode ties start to 0.
REQ-031 Latency SHALL NOT depend on WIDTH; no additional pipeline stages are permitted.

Verification (WIDTH=8)
REQ-032 Fixed mode, in=8'b0010_0100 for one cycle, out_ready=1: grants out_idx 2 then 5 on consecutive cycles, then out_valid=0; pending ends 0.
REQ-033 Fixed mode, out_ready=0, in=8'h01 for one cycle then again 3 cycles later: out_idx=0 is held stable, pending[0]=1, no overflow pulse.
- Then a third in=8'h01 gives a single overflow pulse.
REQ-034 RR mode, in=8'hFF held continuously, out_ready=1: out_idx sequence 0,1,...,7,0,1, with one grant per cycle after 2-cycle initial latency.
REQ-035 Backpressure: out_ready toggles 1,0,1,0 with pending=8'h0F: each index 0..3 is accepted exactly once; out_idx never changes while out_valid && !out_ready.
REQ-036 clear asserted together with in=8'h80 while out_valid=1: next cycle out_valid=0, pending=0, and index 7 is never granted.
REQ-037 rst pulsed asynchronously between edges with out_valid=1 and pending=8'h30: outputs go to 0 before the next edge; RR restarts search at index 0.

Source files
------------

// File: rtl/pending_encoder_pkg.sv
// pending_encoder_pkg
// Shared constants and helpers for the pending request encoder.
//   PRIO_FIXED / PRIO_RR : values for the ROUND_ROBIN parameter.
//   idx_width()          : index width for an N-entry vector. It never returns 0,
//                          so an index port always has at least one bit.
package pending_encoder_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pending_encoder_prio_pick.sv
// prio_pick
// Combinational selector. It picks the first set request found at or above
// i_start and wraps around to index 0 if nothing is set there.
//   i_req    [WIDTH] : request vector
//   i_start  [IDXW]  : first index to consider. Tie it to 0 for plain lowest-index priority.
//   o_onehot [WIDTH] : one-hot mask of the selected request
//   o_idx    [IDXW]  : encoded index of the selected request
//   o_found          : at least one request is set
module prio_pick
    import pending_encoder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [IDXW-1:0]  i_start,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_found
);

    logic [WIDTH-1:0] w_hi_mask;
    logic [WIDTH-1:0] w_hi_req;
    logic [WIDTH-1:0] w_search;

    // Thermometer mask covering the bits at or above the start index.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign w_hi_mask[gi] = (IDXW'(gi) >= i_start);
    end

    assign w_hi_req = i_req & w_hi_mask;

    // If no request is set at or above the start index, the search wraps.
    // The lowest set bit of the full vector is then the correct pick.
    assign w_search = (|w_hi_req) ? w_hi_req : i_req;

    // Isolate the lowest set bit with the two's-complement trick.
    assign o_onehot = w_search & (~w_search + WIDTH'(1));
    assign o_found  = |i_req;

    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_search[i]) begin
                o_idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/pending_encoder.sv
// pending_encoder
// Collects request pulses into a pending set. One request per cycle moves into
// a registered output stage, which has a valid/ready handshake.
//   clk, rst   : clock; asynchronous active-high reset
//   in         : request lines, sampled every cycle
//   clear      : synchronous flush of the pending set and the output stage
//   out_idx    : index of the granted request (registered)
//   out_valid  : out_idx holds a grant
//   out_ready  : consumer accepts the grant when out_valid && out_ready
//   pending    : requests still waiting; excludes the one in the output stage
//   overflow   : one-cycle pulse when a request hits a bit that is already pending
module pending_encoder
    import pending_encoder_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int ROUND_ROBIN = PRIO_FIXED,
    localparam int IDXW        = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             clear,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);

    logic [WIDTH-1:0] r_pending;
    logic             r_out_valid;
    logic [IDXW-1:0]  r_out_idx;
    logic [IDXW-1:0]  r_last_idx;
    logic             r_overflow;

    logic [IDXW-1:0]  w_start;
    logic [IDXW-1:0]  w_rr_start;
    logic [WIDTH-1:0] w_onehot;
    logic [IDXW-1:0]  w_idx;
    logic             w_found;
    logic             w_can_load;
    logic             w_load;
    logic [WIDTH-1:0] w_load_mask;

    // The round-robin search begins one past the last grant and wraps at WIDTH.
    // WIDTH need not be a power of two, so the wrap is an explicit compare.
    assign w_rr_start = (r_last_idx == IDXW'(WIDTH - 1)) ? '0 : r_last_idx + IDXW'(1);
    assign w_start    = (ROUND_ROBIN == PRIO_RR) ? w_rr_start : '0;

    prio_pick #(
        .WIDTH    (WIDTH)
    ) u_pick (
        .i_req    (r_pending),
        .i_start  (w_start),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_found  (w_found)
    );

    assign w_can_load  = !r_out_valid || out_ready;
    assign w_load      = w_can_load && w_found;
    assign w_load_mask = w_load ? w_onehot : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_overflow  <= 1'b0;
            r_last_idx  <= IDXW'(WIDTH - 1);
        end else if (clear) begin
            // Flush the pending set and the output stage. r_out_idx and
            // r_last_idx keep their values, so round-robin fairness survives
            // a flush.
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // A bit being loaded this cycle counts as free. A request on that
            // same bit re-arms it without raising overflow.
            r_pending  <= (r_pending & ~w_load_mask) | in;
            r_overflow <= |(in & r_pending & ~w_load_mask);
            if (w_can_load) begin
                r_out_valid <= w_found;
                if (w_load) begin
                    r_out_idx  <= w_idx;
                    r_last_idx <= w_idx;
                end
            end
        end
    end

    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pending_encoder.sv
// tb_pending_encoder
// Drives a fixed-priority instance and a round-robin instance (WIDTH=8) with the
// same inputs. Both are checked every cycle against a behavioural model.
// Directed scenarios come first, then randomized traffic.
module tb_pending_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_v = '0;
    logic       clear_v = 1'b0;
    logic       ready_v = 1'b0;

    logic [2:0] idx_f, idx_r;
    logic       v_f, v_r, ovf_f, ovf_r;
    logic [7:0] pend_f, pend_r;

    int checks = 0;
    int errors = 0;

    // Model state. Index 0 is the fixed-priority instance; index 1 is round-robin.
    logic [7:0] m_pend  [2];
    logic       m_valid [2];
    logic [2:0] m_idx   [2];
    logic       m_ovf   [2];
    int         m_last  [2];

    always #5 clk = ~clk;

    pending_encoder #(.WIDTH(8), .ROUND_ROBIN(0)) u_fixed (
        .clk(clk), .rst(rst), .in(in_v), .clear(clear_v),
        .out_idx(idx_f), .out_valid(v_f), .out_ready(ready_v),
        .pending(pend_f), .overflow(ovf_f)
    );

    pending_encoder #(.WIDTH(8), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst), .in(in_v), .clear(clear_v),
        .out_idx(idx_r), .out_valid(v_r), .out_ready(ready_v),
        .pending(pend_r), .overflow(ovf_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Selection rule: walk upward from the start point with modulo wrap.
    function automatic int pick(input int mode, input logic [7:0] p, input int last);
        int start;
        start = (mode == 0) ? 0 : (last + 1) % 8;
        for (int k = 0; k < 8; k++) begin
            if (p[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_valid[m] = 1'b0; m_idx[m] = '0; m_ovf[m] = 1'b0; m_last[m] = 7;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            logic [7:0] lm;
            int p;
            lm = '0;
            if (clear_v) begin
                m_pend[m] = '0; m_valid[m] = 1'b0; m_ovf[m] = 1'b0;
            end else begin
                if (!m_valid[m] || ready_v) begin
                    if (m_pend[m] != 0) begin
                        p = pick(m, m_pend[m], m_last[m]);
                        lm = 8'd1 << p;
                        m_valid[m] = 1'b1;
                        m_idx[m] = 3'(p);
                        m_last[m] = p;
                    end else begin
                        m_valid[m] = 1'b0;
                    end
                end
                m_ovf[m]  = |(in_v & m_pend[m] & ~lm);
                m_pend[m] = (m_pend[m] & ~lm) | in_v;
            end
        end
    endtask

    task automatic compare_all();
        check("fix_valid", 32'(v_f),    32'(m_valid[0]));
        check("fix_idx",   32'(idx_f),  32'(m_idx[0]));
        check("fix_pend",  32'(pend_f), 32'(m_pend[0]));
        check("fix_ovf",   32'(ovf_f),  32'(m_ovf[0]));
        check("rr_valid",  32'(v_r),    32'(m_valid[1]));
        check("rr_idx",    32'(idx_r),  32'(m_idx[1]));
        check("rr_pend",   32'(pend_r), 32'(m_pend[1]));
        check("rr_ovf",    32'(ovf_r),  32'(m_ovf[1]));
    endtask

    // One clock cycle. Inputs are already set. Before the edge, print the
    // handshakes that complete on it; after the edge, advance the model and compare.
    task automatic step();
        if (v_f && ready_v) $display("grant fixed idx=%0d", idx_f);
        if (v_r && ready_v) $display("grant rr    idx=%0d", idx_r);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Pulses reset between edges and checks that the outputs clear before any edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        async_reset();

        // Fixed priority, two requests in one pulse: grants 2, then 5, then idle.
        ready_v = 1'b1; in_v = 8'b0010_0100; step();
        in_v = '0; step();
        check("d1_idx2", 32'(idx_f), 32'd2);
        step();
        check("d1_idx5", 32'(idx_f), 32'd5);
        step();
        check("d1_idle", 32'(v_f), 32'd0);
        check("d1_pend0", 32'(pend_f), 32'd0);

        // Round-robin, all lines held: one grant per cycle, cycling through 0..7.
        async_reset();
        in_v = 8'hFF; step();
        for (int k = 0; k < 10; k++) begin
            step();
            check("d2_rr_seq", 32'(idx_r), 32'(k % 8));
        end
        in_v = '0;

        // Stalled output stage: a re-request is stored quietly; the next one overflows.
        async_reset();
        ready_v = 1'b0; in_v = 8'h01; step();
        in_v = '0; step(); step(); step();
        in_v = 8'h01; step();
        in_v = '0; step();
        check("d3_hold_idx", 32'(idx_f), 32'd0);
        check("d3_pend_bit", 32'(pend_f[0]), 32'd1);
        check("d3_no_ovf", 32'(ovf_f), 32'd0);
        in_v = 8'h01; step();
        check("d3_ovf", 32'(ovf_f), 32'd1);
        in_v = '0; step();
        check("d3_ovf_end", 32'(ovf_f), 32'd0);

        // Backpressure over pending 0..3 with out_ready toggling.
        async_reset();
        ready_v = 1'b0; in_v = 8'h0F; step();
        in_v = '0;
        for (int k = 0; k < 10; k++) begin
            ready_v = k[0]; step();
        end
        check("d4_drained", 32'(pend_f), 32'd0);

        // Clear during a held grant drops both the grant and the new request.
        async_reset();
        ready_v = 1'b0; in_v = 8'h01; step();
        in_v = '0; step();
        clear_v = 1'b1; in_v = 8'h80; step();
        check("d5_clr_valid", 32'(v_f), 32'd0);
        check("d5_clr_pend", 32'(pend_f), 32'd0);
        clear_v = 1'b0; in_v = '0; ready_v = 1'b1;
        repeat (3) step();
        check("d5_no_grant7", 32'(v_f), 32'd0);

        // Async reset while a grant is held and 0x30 is pending; round-robin then restarts at 0.
        async_reset();
        ready_v = 1'b0; in_v = 8'h01; step();
        in_v = 8'h30; step();
        in_v = '0;
        check("d6_pre_pend", 32'(pend_r), 32'h30);
        async_reset();
        in_v = 8'h81; ready_v = 1'b1; step();
        in_v = '0; step();
        check("d6_rr_restart", 32'(idx_r), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            in_v    = (n % 50 < 10) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            clear_v = ($urandom_range(0, 29) == 0);
            ready_v = ($urandom_range(0, 2) != 0);
            step();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
